// File: rtl/pool_row_pair_buffer_pkg.sv
// Shared constants and types for the max-pool row-pair feeder.
// MAX_NUM and SPOOL_1 mirror the values the rest of the accelerator uses.
package pool_row_pair_buffer_pkg;

  localparam int MAX_NUM = 15;
  localparam logic [3:0] SPOOL_1 = 4'd5;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } fill_state_t;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_row_pair_buffer_if.sv
// Pixel-in / row-pair-out handshake bundle between the conv stage, this buffer and the pool array.
interface pool_row_pair_buffer_if #(
  parameter int PIX_W = 16
);
  import pool_row_pair_buffer_pkg::*;

  logic [PIX_W-1:0]           pix_in;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [MAX_NUM*4*PIX_W-1:0] fm_out;
  logic [MAX_NUM-1:0]         max_en;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  modport master (
    output pix_in, pix_valid, out_ready,
    input  pix_ready, fm_out, max_en, out_valid, out_last
  );

  modport slave (
    input  pix_in, pix_valid, out_ready,
    output pix_ready, fm_out, max_en, out_valid, out_last
  );

endinterface

// File: rtl/pool_row_pair_buffer_row_reg.sv
// One feature-map row held as ROW_LEN pixel registers, written one pixel at a time.
module pool_row_reg #(
  parameter int PIX_W   = 16,
  parameter int ROW_LEN = 28,
  parameter int IDX_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [PIX_W-1:0]         din,
  output logic [ROW_LEN*PIX_W-1:0] row
);

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
    end else if (we) begin
      row[idx*PIX_W +: PIX_W] <= din;
    end
  end

endmodule

// File: rtl/pool_row_pair_buffer.sv
// Assembles two consecutive conv-output rows into the packed fm_out/max_en vector
// consumed by the 2x2 max-pool array; one row pair in flight at a time.
module pool_row_pair_buffer
  import pool_row_pair_buffer_pkg::*;
#(
  parameter int PIX_W    = 16,
  parameter int ROW_LEN  = 28,
  parameter int MAP_ROWS = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             CS,
  pool_row_pair_buffer_if.slave  bus
);

  localparam int COL_W  = cnt_w(ROW_LEN);
  localparam int PAIR_W = cnt_w(MAP_ROWS / 2);
  localparam int ROW_W  = ROW_LEN * PIX_W;
  localparam int FM_W   = MAX_NUM * 4 * PIX_W;
  localparam logic [MAX_NUM-1:0] EN_MASK = MAX_NUM'((1 << (ROW_LEN / 2)) - 1);

  fill_state_t       state;
  logic [COL_W-1:0]  col;
  logic [PAIR_W-1:0] pair;
  logic [ROW_W-1:0]  row_a;
  logic [ROW_W-1:0]  row_b;
  logic              cs_on;
  logic              pix_acc;
  logic              pair_take;
  logic              row_end;
  logic              pair_end;

  assign cs_on         = (CS == SPOOL_1);
  assign bus.pix_ready = ((state == FILL_A) || (state == FILL_B)) && cs_on;
  assign pix_acc       = bus.pix_valid && bus.pix_ready;
  assign bus.out_valid = (state == HOLD);
  assign pair_take     = bus.out_valid && bus.out_ready;
  assign row_end       = (col == COL_W'(ROW_LEN - 1));
  assign pair_end      = (pair == PAIR_W'(MAP_ROWS / 2 - 1));

  // A pair can be taken even while CS is elsewhere; only pixel intake is gated by CS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL_A;
      col   <= '0;
      pair  <= '0;
    end else begin
      if (pix_acc) begin
        col <= row_end ? '0 : col + 1'b1;
        if (row_end) begin
          state <= (state == FILL_A) ? FILL_B : HOLD;
        end
      end
      if (pair_take) begin
        state <= FILL_A;
        pair  <= pair_end ? '0 : pair + 1'b1;
      end
    end
  end

  pool_row_reg #(.PIX_W(PIX_W), .ROW_LEN(ROW_LEN), .IDX_W(COL_W)) u_row_a (
    .clk (clk),
    .rst (rst),
    .we  (pix_acc && (state == FILL_A)),
    .idx (col),
    .din (bus.pix_in),
    .row (row_a)
  );

  pool_row_reg #(.PIX_W(PIX_W), .ROW_LEN(ROW_LEN), .IDX_W(COL_W)) u_row_b (
    .clk (clk),
    .rst (rst),
    .we  (pix_acc && (state == FILL_B)),
    .idx (col),
    .din (bus.pix_in),
    .row (row_b)
  );

  assign bus.fm_out   = {{(FM_W - 2 * ROW_W){1'b0}}, row_b, row_a};
  assign bus.max_en   = bus.out_valid ? EN_MASK : '0;
  assign bus.out_last = bus.out_valid && pair_end;

endmodule
